// File: rtl/acc_prog_loader.sv
// Byte-stream program loader and run supervisor for the accumulator CPU.
// Writes a length-prefixed program into imem, releases the CPU, captures the halt result.
module acc_prog_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halted,
    input  logic [DATA_W-1:0] cpu_acc,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;

    logic accept;
    logic timeout;

    assign accept  = in_valid & in_ready;
    assign timeout = (wdog_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && in_data != 8'd0) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (accept && rem_q == 8'd1) state_d = S_RUN;
            end
            S_RUN: begin
                if (cpu_halted || timeout) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // After a clean halt the CPU is left running so its state stays visible.
    always_comb begin
        in_ready  = (state_q != S_RUN);
        cpu_reset = !((state_q == S_RUN) ||
                      (state_q == S_DONE && halted_q));
    end

    always_comb begin
        rem_d    = rem_q;
        idx_d    = idx_q;
        wdog_d   = '0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        result_d = result_q;
        err_d    = err_q;
        halted_d = halted_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (in_data == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d    = in_data;
                        idx_d    = '0;
                        err_d    = 1'b0;
                        done_d   = 1'b0;
                        halted_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = DATA_W'(in_data);
                    idx_d   = idx_q + ADDR_W'(1);
                    rem_d   = rem_q - 8'd1;
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + CNT_W'(1);
                if (cpu_halted) begin
                    result_d = cpu_acc;
                    done_d   = 1'b1;
                    halted_d = 1'b1;
                end else if (timeout) begin
                    result_d = '0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            idx_q    <= '0;
            wdog_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            wdog_q   <= wdog_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule
